// File: rtl/mult_booth_seq.sv
// mult_booth_seq
//   Sequential radix-2 Booth multiplier controller. Computes a signed 32x32
//   multiply by steering the shared execute-stage ALU through add/sub steps,
//   one Booth iteration per cycle, and returns the low 32 product bits plus
//   an overflow flag.
//
// Ports
//   clock, reset_n               clock and asynchronous active-low reset
//   ctrl_MULT                    start pulse (ignored while busy)
//   data_operandA/B              multiplicand / multiplier (two's complement)
//   data_result                  low 32 bits of the product (registered)
//   data_exception               product does not fit in 32 bits (registered)
//   data_resultRDY               one-cycle completion pulse (registered)
//   alu_operandA/B, alu_opcode   ALU drive: A accumulator, M multiplicand,
//   alu_shiftamt                 opcode 0 = add, 1 = sub, shift amount 0
//   alu_result, alu_overflow     combinational ALU return
//   alu_req, alu_gnt             ALU arbitration (MULT_BOOTH_SHARE_EN only)
//
// Configuration
//   MULT_BOOTH_SHARE_EN  adds alu_req/alu_gnt; ALU iterations stall until
//                        granted. Without it the grant is always assumed.
module mult_booth_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shiftamt,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow
`ifdef MULT_BOOTH_SHARE_EN
    ,
    output logic        alu_req,
    input  logic        alu_gnt
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;

    state_t      state, state_nxt;
    logic [31:0] m_reg, a_reg, q_reg;
    logic        q1_reg;
    logic [5:0]  cnt;

    logic [1:0]  pair;
    logic        alu_iter, gnt, advance, last;
    logic [31:0] sum;
    logic        s32;
    logic [31:0] a_nxt, q_nxt;

    assign pair     = {q_reg[0], q1_reg};
    assign alu_iter = (pair == 2'b01) || (pair == 2'b10);

`ifdef MULT_BOOTH_SHARE_EN
    assign gnt = alu_gnt;
`else
    assign gnt = 1'b1;
`endif

    // Pass iterations (00/11) never need the ALU, so they never wait for it.
    assign advance = (state == BUSY) && (!alu_iter || gnt);
    assign last    = (cnt == 6'd31);

    // 33rd sum bit: the true sign of A +/- M is the ALU sign bit corrected
    // by its overflow flag, which keeps M = 0x80000000 exact.
    assign sum   = alu_iter ? alu_result : a_reg;
    assign s32   = alu_iter ? (alu_result[31] ^ alu_overflow) : a_reg[31];
    assign a_nxt = {s32, sum[31:1]};
    assign q_nxt = {sum[0], q_reg[31:1]};

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ctrl_MULT)       state_nxt = BUSY;
            BUSY: if (advance && last) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Output logic: ALU drive (zero while idle)
    always_comb begin
        alu_operandA = '0;
        alu_operandB = '0;
        alu_opcode   = OP_ADD;
        alu_shiftamt = '0;
`ifdef MULT_BOOTH_SHARE_EN
        alu_req      = 1'b0;
`endif
        if (state == BUSY) begin
            alu_operandA = a_reg;
            alu_operandB = m_reg;
            alu_opcode   = (pair == 2'b10) ? OP_SUB : OP_ADD;
`ifdef MULT_BOOTH_SHARE_EN
            alu_req      = alu_iter;
`endif
        end
    end

    // Booth datapath and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_reg          <= '0;
            a_reg          <= '0;
            q_reg          <= '0;
            q1_reg         <= 1'b0;
            cnt            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (state == IDLE && ctrl_MULT) begin
                m_reg  <= data_operandA;
                q_reg  <= data_operandB;
                a_reg  <= '0;
                q1_reg <= 1'b0;
                cnt    <= '0;
            end else if (advance) begin
                a_reg  <= a_nxt;
                q_reg  <= q_nxt;
                q1_reg <= q_reg[0];
                cnt    <= cnt + 6'd1;
                if (last) begin
                    data_result    <= q_nxt;
                    // Fits in 32 bits only if the high word is pure sign.
                    data_exception <= (a_nxt != {32{q_nxt[31]}});
                    data_resultRDY <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_booth_seq.sv
module tb_mult_booth_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [31:0] alu_operandA, alu_operandB;
    logic [4:0]  alu_opcode, alu_shiftamt;
    logic [31:0] alu_result;
    logic        alu_overflow;
`ifdef MULT_BOOTH_SHARE_EN
    logic        alu_req;
    logic        alu_gnt = 1'b1;
`endif

    int compared = 0;
    int mismatched = 0;

    mult_booth_seq dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .alu_operandA   (alu_operandA),
        .alu_operandB   (alu_operandB),
        .alu_opcode     (alu_opcode),
        .alu_shiftamt   (alu_shiftamt),
        .alu_result     (alu_result),
        .alu_overflow   (alu_overflow)
`ifdef MULT_BOOTH_SHARE_EN
        ,
        .alu_req        (alu_req),
        .alu_gnt        (alu_gnt)
`endif
    );

    always #5 clock = ~clock;

    // Behavioural ALU: add/sub with signed overflow.
    logic [31:0] alu_sum;
    always_comb begin
        if (alu_opcode == 5'd1) begin
            alu_sum      = alu_operandA - alu_operandB;
            alu_overflow = (alu_operandA[31] != alu_operandB[31]) &&
                           (alu_sum[31] != alu_operandA[31]);
        end else begin
            alu_sum      = alu_operandA + alu_operandB;
            alu_overflow = (alu_operandA[31] == alu_operandB[31]) &&
                           (alu_sum[31] != alu_operandA[31]);
        end
        alu_result = alu_sum;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    // Drive operands, let the next edge sample them, then scramble operands.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock); #1;
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Count edges until RDY (bounded); leaves us inside the RDY cycle.
    task automatic wait_done(input string name, input int exp_lat,
                             input logic [31:0] exp_r, input logic exp_e);
        int n;
        n = 0;
        while (!data_resultRDY && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_result"}, data_result, exp_r);
        chk({name, "_exception"}, {31'd0, data_exception}, {31'd0, exp_e});
    endtask

    task automatic chk_pulse_end(input string name);
        @(posedge clock); #1;
        chk({name, "_rdy_fall"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        int seen;
        // Reset state
        #12;
        chk("rst_result", data_result, 32'd0);
        chk("rst_exception", {31'd0, data_exception}, 32'd0);
        chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("rst_alu_a", alu_operandA, 32'd0);
        chk("rst_alu_b", alu_operandB, 32'd0);
        chk("rst_alu_op", {27'd0, alu_opcode}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // 3 x 5: first iteration pair is 10 -> subtract M from A=0
        start_op(32'd3, 32'd5);
        chk("busy_alu_a", alu_operandA, 32'd0);
        chk("busy_alu_b", alu_operandB, 32'd3);
        chk("busy_alu_op", {27'd0, alu_opcode}, 32'd1);
        chk("busy_shamt", {27'd0, alu_shiftamt}, 32'd0);
        wait_done("3x5", 32, 32'd15, 1'b0);
        chk_pulse_end("3x5");
        chk("idle_alu_b", alu_operandB, 32'd0);

        // -7 x 6, then back-to-back start in the RDY cycle
        start_op(32'hFFFF_FFF9, 32'd6);
        wait_done("m7x6", 32, 32'hFFFF_FFD6, 1'b0);
        start_op(32'd1343, 32'd100000);
        chk("b2b_rdy_fall", {31'd0, data_resultRDY}, 32'd0);
        chk("b2b_result_hold", data_result, 32'hFFFF_FFD6);
        chk("b2b_alu_b", alu_operandB, 32'd1343);
        wait_done("1343x100000", 32, 32'd134300000, 1'b0);
        chk_pulse_end("1343x100000");

        // Boundaries
        start_op(32'd0, 32'h7FFF_FFFF);
        wait_done("0xmax", 32, 32'd0, 1'b0);
        start_op(32'd65536, 32'd65536);
        wait_done("2p16sq", 32, 32'd0, 1'b1);
        start_op(32'h8000_0000, 32'd1);
        wait_done("min_x1", 32, 32'h8000_0000, 1'b0);
        start_op(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("min_xm1", 32, 32'h8000_0000, 1'b1);
        chk_pulse_end("min_xm1");

        // Abort 9 x 9 with reset at cycle 10
        start_op(32'd9, 32'd9);
        repeat (9) @(posedge clock);
        #1;
        chk("abort_pre_alu_b", alu_operandB, 32'd9);
        reset_n = 1'b0;
        #1;
        chk("abort_result", data_result, 32'd0);
        chk("abort_exception", {31'd0, data_exception}, 32'd0);
        chk("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("abort_alu_a", alu_operandA, 32'd0);
        chk("abort_alu_b", alu_operandB, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (data_resultRDY) seen++;
        end
        chk("abort_no_rdy", seen, 32'd0);
        start_op(32'd9, 32'd9);
        wait_done("9x9", 32, 32'd81, 1'b0);

`ifdef MULT_BOOTH_SHARE_EN
        // 3 x 5 with grant withheld for 20 edges after the start edge
        @(posedge clock); #1;
        alu_gnt = 1'b0;
        start_op(32'd3, 32'd5);
        chk("stall_req", {31'd0, alu_req}, 32'd1);
        repeat (20) @(posedge clock);
        #1;
        chk("stall_req_held", {31'd0, alu_req}, 32'd1);
        chk("stall_alu_op", {27'd0, alu_opcode}, 32'd1);
        chk("stall_alu_b", alu_operandB, 32'd3);
        chk("stall_no_rdy", {31'd0, data_resultRDY}, 32'd0);
        alu_gnt = 1'b1;
        wait_done("stall3x5", 32, 32'd15, 1'b0);
        chk_pulse_end("stall3x5");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mult_booth_seq.md
# mult_booth_seq

Sequential radix-2 Booth multiplier controller that computes a signed 32x32 multiply by sequencing the processor's shared ALU through add and subtract operations. It latches the operands on a start pulse and drives the ALU operand and opcode ports for one iteration per cycle. It keeps the Booth product register internally and returns a 32-bit result with an overflow exception flag. It sits beside the ALU in the execute stage and serves the MULT instruction path.

## Interface
- No parameters. Width is fixed at 32 bits, and the iteration count is fixed at 32.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `ctrl_MULT` input 1: start pulse; sampled on the rising edge.
- `data_operandA` input 32: multiplicand, two's complement.
- `data_operandB` input 32: multiplier, two's complement.
- `data_result` output 32: low 32 bits of the product; registered.
- `data_exception` output 1: high when the full 64-bit product is not representable in 32 bits; registered.
- `data_resultRDY` output 1: one-cycle completion pulse; registered.
- `alu_operandA` output 32: accumulator A driven to the ALU.
- `alu_operandB` output 32: latched multiplicand M driven to the ALU.
- `alu_opcode` output 5: 5'b00000 = add, 5'b00001 = sub.
- `alu_shiftamt` output 5: constant 0.
- `alu_result` input 32: ALU result (combinational return).
- `alu_overflow` input 1: ALU signed-overflow flag.
- Present only with `MULT_BOOTH_SHARE_EN` (see Configuration):
  - `alu_req` output 1: ALU request.
  - `alu_gnt` input 1: ALU grant.

## Operation
- Registers:
  - state: IDLE or BUSY.
  - M: 32-bit multiplicand.
  - A: 32-bit accumulator.
  - Q: 32-bit multiplier/low product.
  - q_1: 1-bit Booth history bit.
  - cnt: 6-bit iteration counter.
- IDLE with ctrl_MULT=1 at an edge:
  - M <= data_operandA, Q <= data_operandB, A <= 0, q_1 <= 0, cnt <= 0.
  - Go to BUSY.
- BUSY iteration, one per advancing edge, selected by pair {Q[0], q_1}:
  - 01: S = A + M. ALU opcode = add.
  - 10: S = A - M. ALU opcode = sub.
  - 00 or 11: S = A. The ALU result is unused.
- 33-bit sign extension of the partial sum:
  - For ALU iterations, the sign bit s32 = alu_result[31] ^ alu_overflow.
  - For pass iterations, s32 = A[31].
  - This makes M = 0x80000000 correct.
- Arithmetic right shift of {s32, S, Q, q_1} by one:
  - A <= {s32, S[31:1]}, Q <= {S[0], Q[31:1]}, q_1 <= Q[0].
  - The post-shift A always fits in 32 bits.
- cnt increments on every advancing edge.
- Completion: the edge that performs iteration 31 (cnt == 31) also:
  - loads data_result with the final Q,
  - sets data_exception = (final A != {32{final Q[31]}}),
  - sets data_resultRDY = 1,
  - returns the state to IDLE.
- ctrl_MULT is ignored while BUSY, and the in-flight operation continues.
- Driving the ALU ports while BUSY: alu_operandA = A, alu_operandB = M, alu_opcode = add unless the pair is 10, alu_shiftamt = 0.
- Driving the ALU ports while IDLE: all zero.

## Timing
- Reset (reset_n low, asynchronous) sets every register and output to 0 and the state to IDLE:
  - data_result = 0, data_exception = 0, data_resultRDY = 0.
  - ALU port outputs = 0; alu_req = 0.
- Latency: ctrl_MULT sampled at edge E0; data_resultRDY is high for exactly the cycle following edge E0+32 (without stalls).
- data_resultRDY falls at the next edge.
- data_result and data_exception hold until the next completion or reset.
- Back-to-back: ctrl_MULT high during the RDY cycle is accepted, because the state is IDLE.
- Operands are only sampled at the start edge; later changes have no effect.
- Reset asserted mid-operation aborts the operation, with no RDY pulse. After release the block is IDLE.
- The ALU path is combinational within a cycle: alu_result must settle from alu_operandA/alu_opcode before the next edge.

## Configuration
- `MULT_BOOTH_SHARE_EN` defined:
  - The alu_req/alu_gnt ports exist.
  - alu_req = BUSY && pair is 01 or 10.
  - An ALU iteration advances only at an edge where alu_gnt = 1; otherwise A, Q, q_1 and cnt hold (stall).
  - Pass iterations (00/11) advance without a grant.
  - ALU outputs are still driven while stalled.
  - Latency = 33 cycles plus stall cycles.
- `MULT_BOOTH_SHARE_EN` undefined:
  - The ports are absent and the grant is treated as constant 1.
  - Latency is fixed at 33 cycles.

## Test plan
- 3 x 5 -> after 33 cycles data_result = 15, data_exception = 0, one-cycle RDY pulse.
- -7 x 6 -> data_result = 0xFFFFFFD6 (-42), data_exception = 0; back-to-back ctrl_MULT in the RDY cycle with 1343 x 100000 -> 134300000, exception 0.
- 0x80000000 x 0xFFFFFFFF -> data_result = 0x80000000, data_exception = 1; 0x80000000 x 1 -> 0x80000000, exception 0.
- 65536 x 65536 -> data_result = 0, data_exception = 1; 0 x 0x7FFFFFFF -> 0, exception 0.
- reset_n pulsed low at cycle 10 of a 9 x 9 operation -> all outputs 0 immediately, no RDY pulse; a new 9 x 9 then returns 81 after 33 cycles.
- With `MULT_BOOTH_SHARE_EN` and alu_gnt held low for 20 cycles during 3 x 5 -> counter holds on ALU iterations and RDY is delayed accordingly; result still 15.
